// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: command sequencer driving a universal shift register; define ROTATE_EN to rotate instead of fill
module shift_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] A,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] i,
    output logic             SR,
    output logic             SL,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [1:0]         op_q, op_d, s_q, s_d;
    logic [WIDTH-1:0]   i_q, i_d;
    logic               fill_q, fill_d, sr_q, sr_d, sl_q, sl_d;
    logic               busy_q, ready_q, done_q, done_d;
    logic               sr_acc, sl_acc, sr_run, sl_run;

`ifdef ROTATE_EN
    // Serial bits are predicted from A as it will be after the shift in flight, so the register rotates
    logic unused_fill;
    assign unused_fill = fill_q;
    assign sr_acc = A[0];
    assign sl_acc = A[WIDTH-1];
    assign sr_run = A[1];
    assign sl_run = A[WIDTH-2];
`else
    logic unused_a;
    assign unused_a = ^A;
    assign sr_acc = cmd_fill;
    assign sl_acc = cmd_fill;
    assign sr_run = fill_q;
    assign sl_run = fill_q;
`endif

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        fill_d  = fill_q;
        s_d     = 2'b00;
        i_d     = i_q;
        sr_d    = 1'b0;
        sl_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = RUN;
                rem_d   = cmd_count;
                op_d    = cmd_op;
                fill_d  = cmd_fill;
                s_d     = (cmd_op == 2'b11 || cmd_count != '0) ? cmd_op : 2'b00;
                i_d     = (cmd_op == 2'b11) ? cmd_data : i_q;
                sr_d    = (cmd_op == 2'b01 && cmd_count != '0) ? sr_acc : 1'b0;
                sl_d    = (cmd_op == 2'b10 && cmd_count != '0) ? sl_acc : 1'b0;
            end
            RUN: begin
                rem_d = (rem_q == '0) ? '0 : rem_q - CNT_W'(1);
                if (op_q == 2'b11 || rem_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    s_d  = op_q;
                    sr_d = (op_q == 2'b01) ? sr_run : 1'b0;
                    sl_d = (op_q == 2'b10) ? sl_run : 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            op_q    <= 2'b00;
            fill_q  <= 1'b0;
            s_q     <= 2'b00;
            i_q     <= '0;
            sr_q    <= 1'b0;
            sl_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            s_q     <= s_d;
            i_q     <= i_d;
            sr_q    <= sr_d;
            sl_q    <= sl_d;
            busy_q  <= state_d != IDLE;
            ready_q <= state_d == IDLE;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = ready_q;
    assign s         = s_q;
    assign i         = i_q;
    assign SR        = sr_q;
    assign SL        = sl_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb_shift_cmd_seq: directed bench with a model of the downstream universal shift register
module tb_shift_cmd_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [3:0] cmd_count = 4'h0;
    logic       cmd_fill = 1'b0;
    logic [3:0] a_m = 4'h0;
    logic [1:0] s;
    logic [3:0] i;
    logic       SR, SL, busy, done;
    int         vectors = 0;
    int         errors = 0;
    int         act, lat, bad;

    shift_cmd_seq dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
        .A(a_m), .s(s), .i(i), .SR(SR), .SL(SL), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register driven by the DUT
    always @(posedge clk) begin
        case (s)
            2'b01:   a_m <= {SR, a_m[3:1]};
            2'b10:   a_m <= {a_m[2:0], SL};
            2'b11:   a_m <= i;
            default: a_m <= a_m;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one command, then count cycles with s!=00, done latency and handshake violations
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [3:0] cnt,
                           input logic fill, output int n_act, output int n_lat, output int n_bad);
        n_act = 0;
        n_lat = 0;
        n_bad = 0;
        @(negedge clk);
        if (!cmd_ready) n_bad++;
        cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_fill = fill; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s != 2'b00) n_act++;
            if (cmd_ready || !busy) n_bad++;
            if (done) begin
                n_lat = k;
                break;
            end
        end
    endtask

    initial begin
        #12;
        check("rst_s", s, 2'b00);
        check("rst_i", i, 4'h0);
        check("rst_srsl", {SR, SL}, 2'b00);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_ready", cmd_ready, 1'b1);
        @(negedge clk) reset = 1'b1;

        run_cmd(2'b11, 4'b1011, 4'd0, 1'b0, act, lat, bad);
        check("load_act", act, 1);
        check("load_lat", lat, 2);
        check("load_hs", bad, 0);
        check("load_i", i, 4'b1011);
        @(negedge clk);
        check("load_a", a_m, 4'b1011);
        check("load_idle", {cmd_ready, busy, done}, 3'b100);

        run_cmd(2'b01, 4'h0, 4'd3, 1'b1, act, lat, bad);
        check("sr_act", act, 3);
        check("sr_lat", lat, 4);
        check("sr_hs", bad, 0);
        check("sr_a", a_m, 4'b1111);
        check("sr_srsl_done", {SR, SL}, 2'b00);

        run_cmd(2'b11, 4'b1011, 4'd0, 1'b0, act, lat, bad);
        run_cmd(2'b10, 4'h0, 4'd2, 1'b0, act, lat, bad);
        check("sl_act", act, 2);
        check("sl_lat", lat, 3);
        check("sl_a", a_m, 4'b1100);

        run_cmd(2'b10, 4'h0, 4'd0, 1'b1, act, lat, bad);
        check("c0_act", act, 0);
        check("c0_lat", lat, 2);
        check("c0_a", a_m, 4'b1100);

        run_cmd(2'b00, 4'h0, 4'd3, 1'b1, act, lat, bad);
        check("hold_act", act, 0);
        check("hold_lat", lat, 4);
        check("hold_a", a_m, 4'b1100);

        // Reset during the second RUN cycle of a count=5 shift
        @(negedge clk);
        cmd_op = 2'b01; cmd_count = 4'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_s", s, 2'b01);
        #2 reset = 1'b0;
        #1;
        check("ar_s_i", {s, i}, {2'b00, 4'h0});
        check("ar_flags", {SR, SL, busy, done, cmd_ready}, 5'b00001);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("ar_nodone", bad, 0);
        #2 reset = 1'b1;
        cmd_op = 2'b11; cmd_data = 4'b0101; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_s", s, 2'b11);
        check("post_rst_i", i, 4'b0101);
        @(negedge clk);
        check("post_rst_done", done, 1'b1);
        @(negedge clk);
        check("post_rst_a", a_m, 4'b0101);

        // cmd_valid held high back to back
        @(negedge clk);
        cmd_op = 2'b11; cmd_data = 4'b1001; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_op = 2'b01; cmd_count = 4'd1; cmd_fill = 1'b0;
        @(negedge clk);
        check("b2b_c1", {s, busy, cmd_ready}, {2'b11, 2'b10});
        @(negedge clk);
        check("b2b_c2", {s, done, busy, cmd_ready}, {2'b00, 3'b110});
        @(negedge clk);
        check("b2b_c3", {busy, cmd_ready}, 2'b01);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_c4", {s, busy, cmd_ready}, {2'b01, 2'b10});
        @(negedge clk);
        check("b2b_c5", done, 1'b1);
        @(negedge clk);
        check("b2b_a", a_m, 4'b0100);

`ifdef ROTATE_EN
        run_cmd(2'b11, 4'b1000, 4'd0, 1'b0, act, lat, bad);
        run_cmd(2'b10, 4'h0, 4'd4, 1'b0, act, lat, bad);
        check("rotl_act", act, 4);
        check("rotl_a", a_m, 4'b1000);
        run_cmd(2'b01, 4'h0, 4'd1, 1'b1, act, lat, bad);
        check("rotr_a", a_m, 4'b0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/shift_cmd_seq.md
SHIFT_CMD_SEQ -- requirements
Module: shift_cmd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data width of the downstream universal shift register.
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the shift-count field.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  2  00 hold/wait, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 cmd_data  input  WIDTH  parallel-load value.
REQ-009 cmd_count  input  CNT_W  cycles to shift or wait; ignored for load.
REQ-010 cmd_fill  input  1  serial bit injected at the vacated end.
REQ-011 A  input  WIDTH  current downstream register contents; used only when ROTATE_EN is defined.
REQ-012 s  output  2  mode select to the downstream register (00 hold, 01 right, 10 left, 11 load).
REQ-013 i  output  WIDTH  parallel data to the downstream register.
REQ-014 SR / SL  output  1 each  serial-right and serial-left inputs to the downstream register.
REQ-015 busy  output  1  a command is executing.
REQ-016 done  output  1  one-cycle pulse when a command completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-019 On acceptance the block SHALL capture op, data, count and fill, load remaining=count, and enter RUN, except that op=11, or ops 00/01/10 with count=0, SHALL enter RUN for exactly one cycle.
REQ-020 In RUN with op=11 the block SHALL drive s=11 and i=cmd_data for one cycle, then enter DONE.
REQ-021 In RUN with op=01 the block SHALL drive s=01, SR=fill, SL=0 for count cycles.
REQ-022 In RUN with op=10 the block SHALL drive s=10, SL=fill, SR=0 for count cycles.
REQ-023 In RUN with op=00 the block SHALL drive s=00 for count cycles.
REQ-024 For count=0 with op 00/01/10, the single RUN cycle SHALL drive s=00, so no shift occurs.
REQ-025 remaining SHALL decrement once per RUN cycle, and RUN SHALL exit to DONE on the cycle where remaining equals 1 or 0; no wrap-around is permitted.
REQ-026 The first s value SHALL appear in the cycle following the acceptance edge.
REQ-027 In DONE the block SHALL drive s=00 and done=1 for one cycle, then return to IDLE.
REQ-028 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-029 cmd_valid asserted outside IDLE SHALL be ignored, and the command SHALL be held off until cmd_ready.
REQ-030 Outside RUN the block SHALL hold i at its last value and drive SR=SL=0.

Reset
REQ-031 While reset=0 the block SHALL hold state=IDLE, remaining=0, s=00, i=0, SR=0, SL=0, busy=0, done=0 and cmd_ready=1.
REQ-032 Reset asserted mid-command SHALL abort the command with no done pulse, and the block SHALL accept a new command on the first edge after release.

Configuration
REQ-033 When the macro ROTATE_EN is defined, shift ops SHALL ignore cmd_fill and drive SR=A[0] for op=01 and SL=A[WIDTH-1] for op=10, sampled each RUN cycle, so the downstream register rotates.
REQ-034 When ROTATE_EN is undefined, A SHALL be unused and fill behaviour SHALL follow REQ-021 and REQ-022.

Verification
REQ-035 Reset released, then load cmd (op=11, data=1011) -> s=11 and i=1011 for 1 cycle, done 1 cycle later, downstream A=1011.
REQ-036 A=1011, shift right count=3, fill=1 -> s=01 for exactly 3 cycles, done pulse, A=1111.
REQ-037 A=1011, shift left count=2, fill=0 -> s=10 for 2 cycles, A=1100; count=0 -> s stays 00, done after 1 RUN cycle, A unchanged.
REQ-038 Reset pulled low during cycle 2 of a count=5 shift -> outputs immediately at reset values, no done pulse, next command accepted normally.
REQ-039 cmd_valid held high back-to-back -> second command accepted only on the edge after DONE, cmd_ready=0 throughout busy.
REQ-040 With ROTATE_EN defined, A=1000, rotate left count=4 -> A=1000 after done; rotate right count=1 -> A=0100.
